// File: rtl/mem_access_unit_if.sv
// Data-memory port of the memory-stage load/store engine.
// The unit drives the request side; memory answers with ack and read data.
interface mem_access_unit_if;
    logic        DmReq;
    logic        DmWe;
    logic [31:0] DmAddr;
    logic [3:0]  DmByteEn;
    logic [31:0] DmWData;
    logic        DmAck;
    logic [31:0] DmRData;

    modport master (
        output DmReq, DmWe, DmAddr, DmByteEn, DmWData,
        input  DmAck, DmRData
    );

    modport slave (
        input  DmReq, DmWe, DmAddr, DmByteEn, DmWData,
        output DmAck, DmRData
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: lane steering, load extension, write-back.
// MISALIGN_TRAP_EN: drop misaligned accesses and pulse Misaligned instead.
module mem_access_unit (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ExValid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemSize,
    input  logic              LoadSigned,
    input  logic [31:0]       Address,
    input  logic [31:0]       StoreData,
    input  logic [4:0]        DestReg,
    output logic              Stall,
    mem_access_unit_if.master dm,
    output logic              WbValid,
    output logic [31:0]       WbData,
    output logic [4:0]        WbDest,
    output logic              Misaligned
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_n;
    logic        we_q, we_n;
    logic [31:0] addr_q, addr_n;
    logic [3:0]  be_q, be_n;
    logic [31:0] wdata_q, wdata_n;
    logic [1:0]  size_q, size_n;
    logic [1:0]  lane_q, lane_n;
    logic        sign_q, sign_n;
    logic [4:0]  dest_q, dest_n;
    logic        wbv_q, wbv_n;
    logic [31:0] wbd_q, wbd_n;
    logic [4:0]  wbr_q, wbr_n;

    logic        mem_op, is_byte, is_half, is_word, bad;
    logic [1:0]  lane;
    logic [3:0]  st_be;
    logic [31:0] st_data, rsh, ld_val;

    assign mem_op  = MemRead | MemWrite;
    assign is_byte = (MemSize == 2'b10);
    assign is_half = (MemSize == 2'b01);
    assign is_word = !is_byte && !is_half;

    // Lane is already aligned down: half keeps bit 1, word uses lane 0.
    assign lane = is_word ? 2'b00 :
                  is_half ? {Address[1], 1'b0} : Address[1:0];

`ifdef MISALIGN_TRAP_EN
    logic mis_q, mis_n;
    assign bad = (is_half && Address[0]) || (is_word && (Address[1:0] != 2'b00));
    assign Misaligned = mis_q;
`else
    assign bad = 1'b0;
    assign Misaligned = 1'b0;
`endif

    always_comb begin
        st_be   = 4'b1111;
        st_data = StoreData;
        unique case (1'b1)
            is_byte: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{StoreData[7:0]}};
            end
            is_half: begin
                st_be   = 4'b0011 << lane;
                st_data = {2{StoreData[15:0]}};
            end
            default: ;
        endcase
    end

    assign rsh = dm.DmRData >> {lane_q, 3'b000};

    always_comb begin
        ld_val = rsh;
        unique case (1'b1)
            size_q == 2'b10: ld_val = {{24{sign_q & rsh[7]}}, rsh[7:0]};
            size_q == 2'b01: ld_val = {{16{sign_q & rsh[15]}}, rsh[15:0]};
            default:         ld_val = rsh;
        endcase
    end

    always_comb begin
        state_n = state;
        we_n    = we_q;
        addr_n  = addr_q;
        be_n    = be_q;
        wdata_n = wdata_q;
        size_n  = size_q;
        lane_n  = lane_q;
        sign_n  = sign_q;
        dest_n  = dest_q;
        wbv_n   = 1'b0;
        wbd_n   = wbd_q;
        wbr_n   = wbr_q;
`ifdef MISALIGN_TRAP_EN
        mis_n   = (state == IDLE) && ExValid && mem_op && bad;
`endif
        unique case (state)
            IDLE: begin
                if (ExValid && !mem_op) begin
                    wbv_n = 1'b1;
                    wbd_n = Address;
                    wbr_n = DestReg;
                end else if (ExValid && !bad) begin
                    state_n = WAIT;
                    we_n    = MemWrite;
                    addr_n  = {Address[31:2], 2'b00};
                    be_n    = MemWrite ? st_be : 4'b1111;
                    wdata_n = MemWrite ? st_data : 32'h0;
                    size_n  = MemSize;
                    lane_n  = lane;
                    sign_n  = LoadSigned;
                    dest_n  = DestReg;
                end
            end
            WAIT: begin
                if (dm.DmAck) begin
                    state_n = IDLE;
                    if (!we_q) begin
                        wbv_n = 1'b1;
                        wbd_n = ld_val;
                        wbr_n = dest_q;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            sign_q  <= 1'b0;
            dest_q  <= 5'd0;
            wbv_q   <= 1'b0;
            wbd_q   <= 32'h0;
            wbr_q   <= 5'd0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            be_q    <= be_n;
            wdata_q <= wdata_n;
            size_q  <= size_n;
            lane_q  <= lane_n;
            sign_q  <= sign_n;
            dest_q  <= dest_n;
            wbv_q   <= wbv_n;
            wbd_q   <= wbd_n;
            wbr_q   <= wbr_n;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_n;
`endif
        end
    end

    // Request follows the state register, so reset drops it asynchronously.
    assign Stall       = (state == WAIT);
    assign dm.DmReq    = (state == WAIT);
    assign dm.DmWe     = we_q;
    assign dm.DmAddr   = addr_q;
    assign dm.DmByteEn = be_q;
    assign dm.DmWData  = wdata_q;
    assign WbValid     = wbv_q;
    assign WbData      = wbd_q;
    assign WbDest      = wbr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table plus hand-written
// sequences for back-to-back, reset-in-WAIT and held-op corner cases.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ExValid, MemRead, MemWrite, LoadSigned;
    logic [1:0]  MemSize;
    logic [31:0] Address, StoreData;
    logic [4:0]  DestReg;
    logic        Stall, WbValid, Misaligned;
    logic [31:0] WbData;
    logic [4:0]  WbDest;

    int n_cmp = 0;
    int n_err = 0;
    int cur   = -1;

    always #5 Clk = ~Clk;

    mem_access_unit_if dm();

    mem_access_unit dut (
        .Clk(Clk), .Rst(Rst), .ExValid(ExValid),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
        .LoadSigned(LoadSigned), .Address(Address), .StoreData(StoreData),
        .DestReg(DestReg), .Stall(Stall), .dm(dm), .WbValid(WbValid),
        .WbData(WbData), .WbDest(WbDest), .Misaligned(Misaligned)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_wb;
        logic [31:0] e_wbdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h, required %h",
                     name, cur, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sgn, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] d,
                       input logic [31:0] rdat, input int w,
                       input logic [31:0] ea, input logic [3:0] eb,
                       input logic [31:0] ewd, input logic ewb,
                       input logic [31:0] ewbd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = sz; v.sgn = sgn;
        v.addr = a; v.sdata = sd; v.dest = d; v.rdata = rdat;
        v.waits = w; v.e_addr = ea; v.e_be = eb; v.e_wdata = ewd;
        v.e_wb = ewb; v.e_wbdata = ewbd;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        ExValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        MemSize = 2'b00; LoadSigned = 1'b0;
        Address = 32'h0; StoreData = 32'h0; DestReg = 5'd0;
    endtask

    initial begin
        int stalls;
        vec_t v;

        //  rd wr sz  sg addr         sdata        dst rdata     w
        add(0, 1, 2'b00, 0, 32'h100, 32'hDEADBEEF, 1, 32'h0, 2,
            32'h100, 4'b1111, 32'hDEADBEEF, 0, 32'h0);
        add(1, 0, 2'b10, 1, 32'h203, 32'h0, 3, 32'h80112233, 0,
            32'h200, 4'b1111, 32'h0, 1, 32'hFFFFFF80);
        add(0, 1, 2'b01, 0, 32'h42, 32'h0000ABCD, 2, 32'h0, 0,
            32'h40, 4'b1100, 32'hABCDABCD, 0, 32'h0);
        add(0, 1, 2'b10, 0, 32'h11, 32'h12345678, 2, 32'h0, 1,
            32'h10, 4'b0010, 32'h78787878, 0, 32'h0);
        add(1, 0, 2'b01, 0, 32'h46, 32'h0, 7, 32'h87654321, 0,
            32'h44, 4'b1111, 32'h0, 1, 32'h00008765);
        add(1, 0, 2'b01, 1, 32'h44, 32'h0, 8, 32'h1234F00D, 2,
            32'h44, 4'b1111, 32'h0, 1, 32'hFFFFF00D);
        add(1, 0, 2'b10, 0, 32'h301, 32'h0, 9, 32'h80112233, 1,
            32'h300, 4'b1111, 32'h0, 1, 32'h00000022);
        add(1, 0, 2'b00, 1, 32'h400, 32'h0, 31, 32'hCAFEF00D, 0,
            32'h400, 4'b1111, 32'h0, 1, 32'hCAFEF00D);
        add(1, 1, 2'b00, 0, 32'h500, 32'h01020304, 4, 32'hFFFFFFFF, 0,
            32'h500, 4'b1111, 32'h01020304, 0, 32'h0);
        add(0, 1, 2'b11, 0, 32'h600, 32'h55AA55AA, 4, 32'h0, 0,
            32'h600, 4'b1111, 32'h55AA55AA, 0, 32'h0);
        add(0, 0, 2'b00, 0, 32'h7, 32'h0, 5, 32'h0, 0,
            32'h0, 4'b0000, 32'h0, 1, 32'h7);
`ifndef MISALIGN_TRAP_EN
        add(1, 0, 2'b00, 0, 32'h102, 32'h0, 6, 32'h11223344, 0,
            32'h100, 4'b1111, 32'h0, 1, 32'h11223344);
        add(0, 1, 2'b01, 0, 32'h43, 32'h0000BEEF, 6, 32'h0, 0,
            32'h40, 4'b1100, 32'hBEEFBEEF, 0, 32'h0);
`endif

        idle_inputs();
        dm.DmAck = 1'b0; dm.DmRData = 32'h0;
        Rst = 1'b1;
        tick(); tick();
        chk("rst_stall", Stall, 0);
        chk("rst_req", dm.DmReq, 0);
        chk("rst_we", dm.DmWe, 0);
        chk("rst_addr", dm.DmAddr, 0);
        chk("rst_be", dm.DmByteEn, 0);
        chk("rst_wdata", dm.DmWData, 0);
        chk("rst_wbv", WbValid, 0);
        chk("rst_wbd", WbData, 0);
        chk("rst_wbr", WbDest, 0);
        chk("rst_mis", Misaligned, 0);
        Rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            cur = i;
            v = vecs[i];
            ExValid = 1'b1; MemRead = v.rd; MemWrite = v.wr;
            MemSize = v.size; LoadSigned = v.sgn; Address = v.addr;
            StoreData = v.sdata; DestReg = v.dest;
            tick();
            if (v.rd || v.wr) begin
                chk("req", dm.DmReq, 1);
                chk("we", dm.DmWe, v.wr);
                chk("addr", dm.DmAddr, v.e_addr);
                chk("be", dm.DmByteEn, v.e_be);
                if (v.wr) chk("wdata", dm.DmWData, v.e_wdata);
                idle_inputs();
                stalls = 0;
                for (int k = 0; k < v.waits; k++) begin
                    if (Stall) stalls++;
                    chk("early_wb", WbValid, 0);
                    tick();
                end
                if (Stall) stalls++;
                chk("hold_addr", dm.DmAddr, v.e_addr);
                chk("hold_be", dm.DmByteEn, v.e_be);
                dm.DmAck = 1'b1; dm.DmRData = v.rdata;
                tick();
                dm.DmAck = 1'b0; dm.DmRData = 32'h0;
                chk("stall_cycles", stalls, v.waits + 1);
                chk("req_drop", dm.DmReq, 0);
            end else begin
                chk("pt_noreq", dm.DmReq, 0);
                idle_inputs();
            end
            chk("wbvalid", WbValid, v.e_wb);
            if (v.e_wb) begin
                chk("wbdata", WbData, v.e_wbdata);
                chk("wbdest", WbDest, v.dest);
            end
            tick();
            chk("wb_pulse", WbValid, 0);
        end

        // Back-to-back pass-through ops.
        cur = 100;
        ExValid = 1'b1; Address = 32'h7; DestReg = 5'd5;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("b2b_wbv", WbValid, 1);
            chk("b2b_wbd", WbData, 32'h7);
            chk("b2b_wbr", WbDest, 5);
            chk("b2b_req", dm.DmReq, 0);
        end
        idle_inputs();
        tick();
        chk("b2b_end", WbValid, 0);

        // Reset while waiting, then a stale ack.
        cur = 101;
        ExValid = 1'b1; MemRead = 1'b1; Address = 32'h800; DestReg = 5'd3;
        tick();
        chk("rw_req", dm.DmReq, 1);
        idle_inputs();
        #2 Rst = 1'b1;
        #1;
        chk("rw_req_async", dm.DmReq, 0);
        chk("rw_stall", Stall, 0);
        #1 Rst = 1'b0;
        dm.DmAck = 1'b1; dm.DmRData = 32'h12345678;
        tick();
        dm.DmAck = 1'b0;
        chk("rw_stale_wbv", WbValid, 0);
        chk("rw_stale_req", dm.DmReq, 0);
        tick();
        chk("rw_idle_wbv", WbValid, 0);

        // An op held during WAIT is taken on the first IDLE cycle.
        cur = 102;
        ExValid = 1'b1; MemWrite = 1'b1; Address = 32'h900;
        StoreData = 32'hA5A5A5A5;
        tick();
        chk("hold_req", dm.DmReq, 1);
        MemWrite = 1'b0; Address = 32'h99; DestReg = 5'd9;
        tick();
        chk("hold_stall", Stall, 1);
        chk("hold_nowb", WbValid, 0);
        dm.DmAck = 1'b1;
        tick();
        dm.DmAck = 1'b0;
        chk("hold_idle", Stall, 0);
        chk("hold_nowb2", WbValid, 0);
        tick();
        idle_inputs();
        chk("hold_wbv", WbValid, 1);
        chk("hold_wbd", WbData, 32'h99);
        chk("hold_wbr", WbDest, 9);

`ifdef MISALIGN_TRAP_EN
        // Misaligned word load is trapped instead of issued.
        cur = 103;
        tick();
        ExValid = 1'b1; MemRead = 1'b1; Address = 32'h102; DestReg = 5'd6;
        tick();
        idle_inputs();
        chk("trap_mis", Misaligned, 1);
        chk("trap_req", dm.DmReq, 0);
        chk("trap_wbv", WbValid, 0);
        tick();
        chk("trap_pulse", Misaligned, 0);
        chk("trap_req2", dm.DmReq, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
